// File: rtl/lc3_regwrite_tracer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lc3_regwrite_tracer_pkg
//  Brief    : Shared types, default widths and entry-layout helpers for the
//             LC-3 register-write trace buffer.
//  Revision : 1.0  initial release
// ============================================================================
package lc3_regwrite_tracer_pkg;

    // Default field widths for a standard 16-bit, 8-register LC-3
    localparam int c_def_data_w = 16;
    localparam int c_def_reg_aw = 3;
    localparam int c_def_ts_w   = 16;

    // FIFO operation for a cycle, encoded as {pop, push}
    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_PUSH = 2'b01,
        FIFO_POP  = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

    // Packed entry width: {ts, ir, reg, old, new}
    function automatic int entry_width(input int ts_w, input int data_w, input int reg_aw);
        return ts_w + (3 * data_w) + reg_aw;
    endfunction

endpackage : lc3_regwrite_tracer_pkg
`default_nettype wire

// File: rtl/lc3_regwrite_tracer_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : lc3_regwrite_tracer_fifo
//  Brief    : First-word-fall-through synchronous FIFO. A push while full is
//             accepted only when a pop happens in the same cycle. The head
//             reads as zero while the FIFO is empty.
//  Revision : 1.0  initial release
// ============================================================================
module lc3_regwrite_tracer_fifo
    import lc3_regwrite_tracer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;

    logic             w_do_push;
    logic             w_do_pop;
    fifo_op_e         w_op;

    assign full      = (r_count == (c_aw + 1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);
    assign w_op      = fifo_op_e'({w_do_pop, w_do_push});
    assign count     = r_count;
    assign dout      = empty ? '0 : r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            case (w_op)
                FIFO_PUSH: begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    r_count  <= r_count + 1'b1;
                end
                FIFO_POP: begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                    r_count  <= r_count - 1'b1;
                end
                FIFO_BOTH: begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Storage array; contents are don't-care until written since dout is gated by empty
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule : lc3_regwrite_tracer_fifo
`default_nettype wire

// File: rtl/lc3_regwrite_tracer.sv
`default_nettype none
// ============================================================================
//  Module   : lc3_regwrite_tracer
//  Brief    : Register-write trace buffer for the LC-3 datapath. Snoops the
//             regfile write port, keeps a shadow copy of every register and
//             logs qualifying writes as {timestamp, IR, reg, old, new}.
//  Revision : 1.0  initial release
// ============================================================================
module lc3_regwrite_tracer
    import lc3_regwrite_tracer_pkg::*;
#(
    parameter int DATA_W   = c_def_data_w,
    parameter int NUM_REGS = 8,
    parameter int REG_AW   = c_def_reg_aw,
    parameter int DEPTH    = 16,
    parameter int TS_W     = c_def_ts_w,
    parameter int DROP_W   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    change_only,
    input  logic [NUM_REGS-1:0]     watch_mask,
    input  logic                    rf_we,
    input  logic [REG_AW-1:0]       rf_waddr,
    input  logic [DATA_W-1:0]       rf_wdata,
    input  logic [DATA_W-1:0]       ir,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [TS_W-1:0]         out_ts,
    output logic [DATA_W-1:0]       out_ir,
    output logic [REG_AW-1:0]       out_reg,
    output logic [DATA_W-1:0]       out_old,
    output logic [DATA_W-1:0]       out_new,
    output logic [$clog2(DEPTH):0]  count,
    output logic [DROP_W-1:0]       dropped,
    input  logic                    clr_drop
);

    localparam int c_entry_w = entry_width(TS_W, DATA_W, REG_AW);
    localparam int c_new_lsb = 0;
    localparam int c_old_lsb = c_new_lsb + DATA_W;
    localparam int c_reg_lsb = c_old_lsb + DATA_W;
    localparam int c_ir_lsb  = c_reg_lsb + REG_AW;
    localparam int c_ts_lsb  = c_ir_lsb + DATA_W;

    logic [DATA_W-1:0]    r_shadow [NUM_REGS];
    logic [TS_W-1:0]      r_ts;
    logic [DROP_W-1:0]    r_dropped;

    logic [DATA_W-1:0]    w_old;
    logic                 w_capture;
    logic                 w_pop;
    logic                 w_drop;
    logic                 w_full;
    logic                 w_empty;
    logic [c_entry_w-1:0] w_entry;
    logic [c_entry_w-1:0] w_head;

    // Capture qualifier uses the pre-update shadow so change_only sees the old value
    assign w_old     = r_shadow[rf_waddr];
    assign w_capture = en & rf_we & watch_mask[rf_waddr]
                     & (~change_only | (rf_wdata != w_old));
    assign w_pop     = ~w_empty & out_ready;
    assign w_drop    = w_capture & w_full & ~w_pop;
    assign w_entry   = {r_ts, ir, rf_waddr, w_old, rf_wdata};

    lc3_regwrite_tracer_fifo #(
        .WIDTH (c_entry_w),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_capture),
        .pop   (w_pop),
        .din   (w_entry),
        .dout  (w_head),
        .count (count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign out_valid = ~w_empty;
    assign out_ts    = w_head[c_ts_lsb  +: TS_W];
    assign out_ir    = w_head[c_ir_lsb  +: DATA_W];
    assign out_reg   = w_head[c_reg_lsb +: REG_AW];
    assign out_old   = w_head[c_old_lsb +: DATA_W];
    assign out_new   = w_head[c_new_lsb +: DATA_W];
    assign dropped   = r_dropped;

    // Shadow register file follows every write, independent of capture settings
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_shadow[i] <= '0;
            end
        end else if (rf_we) begin
            r_shadow[rf_waddr] <= rf_wdata;
        end
    end

    // Free-running timestamp, wraps at 2^TS_W
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
        end
    end

    // Saturating drop counter; a drop in the clearing cycle still counts as one
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_dropped <= '0;
        end else if (clr_drop) begin
            r_dropped <= w_drop ? DROP_W'(1) : '0;
        end else if (w_drop && (r_dropped != '1)) begin
            r_dropped <= r_dropped + 1'b1;
        end
    end

endmodule : lc3_regwrite_tracer
`default_nettype wire

// File: tb/tb_lc3_regwrite_tracer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lc3_regwrite_tracer
//  Brief    : Self-checking bench for lc3_regwrite_tracer: directed scenarios
//             plus randomized traffic against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lc3_regwrite_tracer;

    localparam int c_depth    = 16;
    localparam int c_drop_max = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic        en, change_only, rf_we, out_ready, clr_drop;
    logic [7:0]  watch_mask;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata, ir;
    logic        out_valid;
    logic [15:0] out_ts, out_ir, out_old, out_new;
    logic [2:0]  out_reg;
    logic [4:0]  count;
    logic [7:0]  dropped;

    lc3_regwrite_tracer dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .change_only (change_only),
        .watch_mask  (watch_mask),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .ir          (ir),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ts      (out_ts),
        .out_ir      (out_ir),
        .out_reg     (out_reg),
        .out_old     (out_old),
        .out_new     (out_new),
        .count       (count),
        .dropped     (dropped),
        .clr_drop    (clr_drop)
    );

    always #5 clk = ~clk;

    // Reference model state
    typedef struct {
        logic [15:0] ts;
        logic [15:0] ir_v;
        logic [2:0]  rg;
        logic [15:0] old_v;
        logic [15:0] new_v;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] msh [8];
    int          m_ts;
    int          m_drop;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        for (int i = 0; i < 8; i++) msh[i] = 16'h0000;
        m_ts   = 0;
        m_drop = 0;
    endtask

    // Apply one clock edge's worth of spec rules to the model
    task automatic model_edge();
        bit   pop, cap, drop;
        int   sz;
        ent_t e;
        sz   = mq.size();
        pop  = (sz > 0) && out_ready;
        cap  = en && rf_we && watch_mask[rf_waddr] &&
               (!change_only || (rf_wdata != msh[rf_waddr]));
        drop = 1'b0;
        e.ts    = 16'(m_ts);
        e.ir_v  = ir;
        e.rg    = rf_waddr;
        e.old_v = msh[rf_waddr];
        e.new_v = rf_wdata;
        if (pop) void'(mq.pop_front());
        if (cap) begin
            if (sz < c_depth || pop) mq.push_back(e);
            else drop = 1'b1;
        end
        if (clr_drop) m_drop = drop ? 1 : 0;
        else if (drop && m_drop < c_drop_max) m_drop++;
        if (rf_we) msh[rf_waddr] = rf_wdata;
        m_ts = (m_ts + 1) % 65536;
    endtask

    task automatic compare_all();
        check_val("count",   64'(count),     64'(mq.size()));
        check_val("valid",   64'(out_valid), 64'(mq.size() > 0));
        check_val("dropped", 64'(dropped),   64'(m_drop));
        if (mq.size() > 0) begin
            check_val("head_ts",  64'(out_ts),  64'(mq[0].ts));
            check_val("head_ir",  64'(out_ir),  64'(mq[0].ir_v));
            check_val("head_reg", 64'(out_reg), 64'(mq[0].rg));
            check_val("head_old", 64'(out_old), 64'(mq[0].old_v));
            check_val("head_new", 64'(out_new), 64'(mq[0].new_v));
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, compare on the falling edge
    task automatic step(input bit e, input bit co, input logic [7:0] m, input bit we,
                        input logic [2:0] wa, input logic [15:0] wd, input logic [15:0] i_ir,
                        input bit rdy, input bit clr);
        en = e; change_only = co; watch_mask = m; rf_we = we;
        rf_waddr = wa; rf_wdata = wd; ir = i_ir; out_ready = rdy; clr_drop = clr;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 16'h0000, 16'h0000, rdy, 1'b0);
    endtask

    // Asynchronous reset: outputs must clear without waiting for an edge
    task automatic apply_reset();
        reset = 1'b0;
        en = 1'b0; change_only = 1'b0; watch_mask = 8'h00; rf_we = 1'b0;
        rf_waddr = 3'd0; rf_wdata = 16'h0000; ir = 16'h0000; out_ready = 1'b0; clr_drop = 1'b0;
        #1;
        check_val("rst_valid",   64'(out_valid), 64'd0);
        check_val("rst_count",   64'(count),     64'd0);
        check_val("rst_dropped", 64'(dropped),   64'd0);
        check_val("rst_out_ts",  64'(out_ts),    64'd0);
        check_val("rst_out_new", 64'(out_new),   64'd0);
        model_clear();
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        logic [15:0] first_data;
        reset = 1'b0;
        @(negedge clk);
        apply_reset();

        // 1: basic capture with timestamp 3
        idle(1'b0); idle(1'b0); idle(1'b0);
        step(1'b1, 1'b0, 8'h03, 1'b1, 3'd0, 16'h0005, 16'h1021, 1'b0, 1'b0);
        check_val("t1_ts",    64'(out_ts),  64'd3);
        check_val("t1_ir",    64'(out_ir),  64'h1021);
        check_val("t1_old",   64'(out_old), 64'h0000);
        check_val("t1_new",   64'(out_new), 64'h0005);
        check_val("t1_count", 64'(count),   64'd1);
        idle(1'b1);

        // 2: change_only suppresses the repeated value
        step(1'b1, 1'b1, 8'h03, 1'b1, 3'd1, 16'h00AA, 16'h5260, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h03, 1'b1, 3'd1, 16'h00AA, 16'h5261, 1'b0, 1'b0);
        check_val("t2_count", 64'(count),   64'd1);
        check_val("t2_new",   64'(out_new), 64'h00AA);
        idle(1'b1);

        // 3: masked write still updates the shadow
        step(1'b1, 1'b0, 8'h01, 1'b1, 3'd2, 16'h1234, 16'h2400, 1'b0, 1'b0);
        check_val("t3_count", 64'(count), 64'd0);
        step(1'b1, 1'b0, 8'h04, 1'b1, 3'd2, 16'h5678, 16'h2401, 1'b0, 1'b0);
        check_val("t3_old",   64'(out_old), 64'h1234);
        idle(1'b1);

        // 4: overflow with the consumer stalled
        apply_reset();
        first_data = 16'($urandom);
        for (int i = 0; i < 18; i++) begin
            step(1'b1, 1'b0, 8'hFF, 1'b1, 3'(i), (i == 0) ? first_data : 16'($urandom),
                 16'(i), 1'b0, 1'b0);
        end
        check_val("t4_count",   64'(count),   64'd16);
        check_val("t4_dropped", 64'(dropped), 64'd2);
        check_val("t4_first",   64'(out_new), 64'(first_data));

        // 5: push+pop while full, then drop/clear interaction
        step(1'b1, 1'b0, 8'hFF, 1'b1, 3'd5, 16'hBEEF, 16'h0F00, 1'b1, 1'b0);
        check_val("t5_count",   64'(count),   64'd16);
        check_val("t5_dropped", 64'(dropped), 64'd2);
        step(1'b1, 1'b0, 8'hFF, 1'b1, 3'd6, 16'hCAFE, 16'h0F01, 1'b0, 1'b1);
        check_val("t5_clrdrop", 64'(dropped), 64'd1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        check_val("t5_clr",     64'(dropped), 64'd0);
        for (int i = 0; i < 16; i++) idle(1'b1);
        check_val("t5_drained", 64'(count), 64'd0);

        // 6: asynchronous reset mid-drain with count 5 and nonzero dropped
        for (int i = 0; i < 22; i++) begin
            step(1'b1, 1'b0, 8'hFF, 1'b1, 3'(i), 16'($urandom), 16'(i), 1'b0, 1'b0);
        end
        for (int i = 0; i < 11; i++) idle(1'b1);
        check_val("t6_pre_count", 64'(count), 64'd5);
        #2;
        apply_reset();

        // Randomized traffic with varying consumer pressure
        for (int blk = 0; blk < 10; blk++) begin
            int rdy_pct;
            rdy_pct = $urandom_range(10, 90);
            for (int i = 0; i < 80; i++) begin
                step($urandom_range(0, 9) != 0, 1'($urandom), 8'($urandom),
                     $urandom_range(0, 9) < 6, 3'($urandom), 16'($urandom_range(0, 3)),
                     16'($urandom), $urandom_range(0, 99) < rdy_pct,
                     $urandom_range(0, 49) == 0);
            end
        end

        // Saturation of the drop counter
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 1'b0, 8'hFF, 1'b1, 3'($urandom), 16'($urandom), 16'($urandom), 1'b0, 1'b0);
        end
        check_val("sat_dropped", 64'(dropped), 64'd255);
        step(1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1, 1'b1);
        check_val("sat_clr", 64'(dropped), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_lc3_regwrite_tracer
`default_nettype wire
